// File: rtl/logical_unit_pipe.sv
// Two-stage elastic bitwise logic unit (AND/OR/XOR/NOR/ANDN) with zero/illegal flags
// and a saturating illegal-opcode counter. Define LOGICAL_PARITY_EN to add ParityFlag.
module logical_unit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             ZeroFlag,
  output logic             IllegalOp,
`ifdef LOGICAL_PARITY_EN
  output logic             ParityFlag,
`endif
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [3:0] {
    OP_AND  = 4'b1011,
    OP_OR   = 4'b1100,
    OP_XOR  = 4'b1101,
    OP_NOR  = 4'b1110,
    OP_ANDN = 4'b1111
  } op_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [3:0]       s1_op;

  logic             s2_advance;
  logic             s1_advance;
  logic [WIDTH-1:0] calc_res;
  logic             calc_illegal;

  assign s2_advance = !out_valid || out_ready;
  assign s1_advance = s1_valid && s2_advance;
  assign in_ready   = !s1_valid || s2_advance;

  always_comb begin
    calc_res     = '0;
    calc_illegal = 1'b0;
    case (s1_op)
      OP_AND:  calc_res = s1_a & s1_b;
      OP_OR:   calc_res = s1_a | s1_b;
      OP_XOR:  calc_res = s1_a ^ s1_b;
      OP_NOR:  calc_res = ~(s1_a | s1_b);
      OP_ANDN: calc_res = s1_a & ~s1_b;
      default: calc_illegal = 1'b1;
    endcase
  end

  // S1 reloads whenever it can accept; an empty slot simply clears s1_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= A;
        s1_b  <= B;
        s1_op <= operation;
      end
    end
  end

  // Data/flag registers only load on a real transfer so bubbles keep the last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      Result     <= '0;
      ZeroFlag   <= 1'b1;
      IllegalOp  <= 1'b0;
`ifdef LOGICAL_PARITY_EN
      ParityFlag <= 1'b0;
`endif
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Result     <= calc_res;
        ZeroFlag   <= (calc_res == '0);
        IllegalOp  <= calc_illegal;
`ifdef LOGICAL_PARITY_EN
        ParityFlag <= ^calc_res;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (s1_advance && calc_illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logical_unit_pipe.sv
// Scoreboard bench for logical_unit_pipe: directed plan vectors plus randomized traffic
// with random backpressure, checked against a behavioural model.
module tb_logical_unit_pipe;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       operation;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             ZeroFlag;
  logic             IllegalOp;
  logic [CNT_W-1:0] illegal_cnt;
`ifdef LOGICAL_PARITY_EN
  logic             ParityFlag;
`endif

  logical_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .operation  (operation),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Result     (Result),
    .ZeroFlag   (ZeroFlag),
    .IllegalOp  (IllegalOp),
`ifdef LOGICAL_PARITY_EN
    .ParityFlag (ParityFlag),
`endif
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zf;
    logic             il;
    logic             par;
    int unsigned      cnt;
    int               acc;
  } exp_t;

  exp_t             exp_q[$];
  int               hs_cyc[$];
  logic [WIDTH-1:0] seen_res[$];
  int               cyc      = 0;
  int               last_lat = -1;
  int unsigned      ill_seen = 0;
  int               n_cmp    = 0;
  int               n_err    = 0;
  bit               rand_rdy = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [WIDTH-1:0] model_res(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                                 logic [3:0] op);
    case (op)
      4'b1011: return a & b;
      4'b1100: return a | b;
      4'b1101: return a ^ b;
      4'b1110: return ~(a | b);
      4'b1111: return a & ~b;
      default: return '0;
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Scoreboard: record expectation at the moment a request is accepted.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      exp_t e;
      e.res = model_res(A, B, operation);
      e.il  = (operation < 4'b1011);
      e.zf  = (e.res == '0);
      e.par = ^e.res;
      if (e.il) ill_seen++;
      e.cnt = (ill_seen > CNT_MAX) ? CNT_MAX : ill_seen;
      e.acc = cyc;
      exp_q.push_back(e);
    end
  end

  // Monitor: compare every presented-and-consumed result against the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got Result %0h expected no output (cycle %0d)",
                 Result, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("Result", 64'(Result), 64'(e.res));
        check("ZeroFlag", 64'(ZeroFlag), 64'(e.zf));
        check("IllegalOp", 64'(IllegalOp), 64'(e.il));
        check("illegal_cnt", 64'(illegal_cnt), 64'(e.cnt));
`ifdef LOGICAL_PARITY_EN
        check("ParityFlag", 64'(ParityFlag), 64'(e.par));
`endif
        last_lat = cyc - e.acc;
        hs_cyc.push_back(cyc);
        seen_res.push_back(Result);
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [3:0] op);
    bit done = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    A         = a;
    B         = b;
    operation = op;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 40 cycles");
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (exp_q.size() != 0 && i < 500) begin
      @(negedge clk);
      i++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic check_reset_values();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_Result", 64'(Result), 64'(0));
    check("rst_ZeroFlag", 64'(ZeroFlag), 64'(1));
    check("rst_IllegalOp", 64'(IllegalOp), 64'(0));
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'(0));
`ifdef LOGICAL_PARITY_EN
    check("rst_ParityFlag", 64'(ParityFlag), 64'(0));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] exp2[5];
    logic [3:0]       ops2[5];
    logic [3:0]       op;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;

    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; operation = '0; out_ready = 1'b1;
    #23;
    check_reset_values();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 check("idle_in_ready", 64'(in_ready), 64'(1));

    // single op, latency
    seen_res.delete();
    send(32'hF0F0_00FF, 32'h0FF0_0F0F, 4'b1011);
    idle();
    drain();
    check("single_latency", 64'(last_lat), 64'(2));
    check("single_result", 64'(seen_res.size() > 0 ? seen_res[0] : 'x), 64'(32'h00F0_000F));

    // all legal ops back-to-back
    ops2 = '{4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    exp2 = '{32'h00FF_0000, 32'hFFFF_00FF, 32'hFF00_00FF, 32'h0000_FF00, 32'hFF00_0000};
    seen_res.delete();
    hs_cyc.delete();
    foreach (ops2[i]) send(32'hFFFF_0000, 32'h00FF_00FF, ops2[i]);
    idle();
    drain();
    check("b2b_count", 64'(seen_res.size()), 64'(5));
    for (int i = 0; i < 5 && i < seen_res.size(); i++) check("b2b_result", 64'(seen_res[i]), 64'(exp2[i]));
    for (int i = 1; i < hs_cyc.size(); i++) check("b2b_no_bubble", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'(1));

    // zero result and illegal opcode
    send(32'hAAAA_AAAA, 32'hAAAA_AAAA, 4'b1101);
    send(32'h1234_5678, 32'h9ABC_DEF0, 4'b0000);
    idle();
    drain();
    check("illegal_cnt_one", 64'(illegal_cnt), 64'(1));
    check("illegal_flag_held", 64'(IllegalOp), 64'(1));

    // backpressure: 3 ops while out_ready low
    @(posedge clk);
    #1 out_ready = 1'b0;
    fork
      begin
        send(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b1011);
        send(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b1100);
        send(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b1101);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_result_first", 64'(Result), 64'(32'h0F0F_0000));
        repeat (2) @(negedge clk);
        check("bp_result_held", 64'(Result), 64'(32'h0F0F_0000));
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

    // saturation: 5 more illegal ops
    for (int i = 0; i < 5; i++) send($urandom, $urandom, 4'(i));
    idle();
    drain();
    check("illegal_cnt_sat", 64'(illegal_cnt), 64'(CNT_MAX));

`ifdef LOGICAL_PARITY_EN
    seen_res.delete();
    send(32'h0000_0007, 32'h0, 4'b1100);
    idle();
    drain();
    check("parity_or7", 64'(ParityFlag), 64'(1));
`endif

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(11 + $urandom_range(0, 4));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
      send(ra, rb, op);
      if ($urandom_range(0, 4) == 0) idle();
    end
    idle();
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    drain();

    // reset mid-stream: pending ops must be dropped
    @(posedge clk);
    #1 out_ready = 1'b0;
    send(32'hDEAD_BEEF, 32'h0000_FFFF, 4'b1100);
    send(32'h1111_1111, 32'h2222_2222, 4'b0001);
    idle();
    rst = 1'b1;
    exp_q.delete();
    ill_seen = 0;
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    #1 check("post_rst_in_ready", 64'(in_ready), 64'(1));
    repeat (10) @(negedge clk);
    check("post_rst_no_output", 64'(out_valid), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
